// File: rtl/score_board_pkg.sv
// ============================================================================
// score_board_pkg : shared widths, saturation ceiling, FSM encoding, BCD helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package score_board_pkg;

  localparam int unsigned SCORE_MAX_DEF = 999999;
  localparam int          BIN_W_DEF     = 24;
  localparam int          DIGITS_DEF    = 6;
  localparam int          LVL_W         = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADD  = 3'd1,
    ST_CLR  = 3'd2,
    ST_CONV = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Double-dabble correction applied to one digit before each shift.
  function automatic logic [3:0] dd_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// bin2bcd_seq : sequential double-dabble, one shift per clock after start
// Revision: 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq
  import score_board_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [BCD_W-1:0] adj;
  logic [SR_W-1:0]  adj_full;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign adj[4*i +: 4] = dd_adjust(sr_q[BIN_W + 4*i +: 4]);
  end

  assign adj_full = {adj, sr_q[BIN_W-1:0]};
  assign bcd      = sr_q[SR_W-1:BIN_W];

  // done flags the cycle whose closing edge performs the final shift.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    run_d = run_q;
    done  = 1'b0;
    if (start) begin
      sr_d  = {{BCD_W{1'b0}}, bin};
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      sr_d  = adj_full << 1;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_ITER) begin
        done  = 1'b1;
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/score_board.sv
// ============================================================================
// score_board : accumulates level bonuses, tracks high score, emits packed BCD
// Revision: 1.0
// ============================================================================
`default_nettype none

module score_board
  import score_board_pkg::*;
#(
  parameter int unsigned SCORE_MAX = SCORE_MAX_DEF,
  parameter int          BIN_W     = BIN_W_DEF,
  parameter int          DIGITS    = DIGITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LVL_W-1:0]     lvl,
  input  logic [BIN_W-1:0]     score_in,
  input  logic                 new_game,
  output logic [4*DIGITS-1:0]  total_bcd,
  output logic [4*DIGITS-1:0]  high_bcd,
  output logic                 busy,
  output logic                 bcd_valid
);

  localparam int BCD_W = 4 * DIGITS;
  localparam logic [BIN_W:0] MAX_EXT = (BIN_W + 1)'(SCORE_MAX);

  state_e             state_q, state_d;
  logic [LVL_W-1:0]   lvl_prev_q, lvl_prev_d;
  logic               armed_q, armed_d;
  logic [BIN_W-1:0]   total_bin_q, total_bin_d;
  logic [BIN_W-1:0]   high_bin_q, high_bin_d;
  logic               pend_add_q, pend_add_d;
  logic               pend_clr_q, pend_clr_d;
  logic               via_clr_q, via_clr_d;
  logic [BCD_W-1:0]   total_bcd_q, total_bcd_d;
  logic [BCD_W-1:0]   high_bcd_q, high_bcd_d;
  logic               busy_q, busy_d;
  logic               bcd_valid_q, bcd_valid_d;

  logic [BIN_W:0]     add_sum;
  logic [BIN_W-1:0]   add_sat;
  logic               lvl_event;
  logic               conv_start;
  logic [BIN_W-1:0]   conv_bin;
  logic [BCD_W-1:0]   conv_bcd;
  logic               conv_done;

  assign add_sum    = {1'b0, total_bin_q} + {1'b0, score_in};
  assign add_sat    = (add_sum > MAX_EXT) ? MAX_EXT[BIN_W-1:0] : add_sum[BIN_W-1:0];
  assign lvl_event  = armed_q && (lvl != lvl_prev_q);
  assign conv_start = (state_q == ST_ADD) || (state_q == ST_CLR);
  assign conv_bin   = (state_q == ST_ADD) ? add_sat : '0;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  always_comb begin
    state_d     = state_q;
    lvl_prev_d  = lvl_prev_q;
    armed_d     = armed_q;
    total_bin_d = total_bin_q;
    high_bin_d  = high_bin_q;
    pend_add_d  = pend_add_q;
    pend_clr_d  = pend_clr_q;
    via_clr_d   = via_clr_q;
    total_bcd_d = total_bcd_q;
    high_bcd_d  = high_bcd_q;
    busy_d      = busy_q;
    bcd_valid_d = 1'b0;

    // The first edge after reset only captures the level, so a stale bus is never credited.
    if (!armed_q) begin
      armed_d    = 1'b1;
      lvl_prev_d = lvl;
    end else if (lvl_event) begin
      lvl_prev_d = lvl;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_clr_q) begin
          state_d = ST_CLR;
          busy_d  = 1'b1;
        end else if (pend_add_q) begin
          state_d = ST_ADD;
          busy_d  = 1'b1;
        end
      end
      ST_ADD: begin
        total_bin_d = add_sat;
        pend_add_d  = 1'b0;
        via_clr_d   = 1'b0;
        state_d     = ST_CONV;
      end
      ST_CLR: begin
        if (total_bin_q > high_bin_q) begin
          high_bin_d = total_bin_q;
          high_bcd_d = total_bcd_q;
        end
        total_bin_d = '0;
        pend_clr_d  = 1'b0;
        via_clr_d   = 1'b1;
        state_d     = ST_CONV;
      end
      ST_CONV: begin
        if (conv_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        total_bcd_d = conv_bcd;
        if ((total_bin_q > high_bin_q) && !via_clr_q) begin
          high_bin_d = total_bin_q;
          high_bcd_d = conv_bcd;
        end
        bcd_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // New events win over the clear in ADD/CLR so nothing arriving mid-flight is dropped.
    if (lvl_event) pend_add_d = 1'b1;
    if (new_game)  pend_clr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lvl_prev_q  <= '0;
      armed_q     <= 1'b0;
      total_bin_q <= '0;
      high_bin_q  <= '0;
      pend_add_q  <= 1'b0;
      pend_clr_q  <= 1'b0;
      via_clr_q   <= 1'b0;
      total_bcd_q <= '0;
      high_bcd_q  <= '0;
      busy_q      <= 1'b0;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lvl_prev_q  <= lvl_prev_d;
      armed_q     <= armed_d;
      total_bin_q <= total_bin_d;
      high_bin_q  <= high_bin_d;
      pend_add_q  <= pend_add_d;
      pend_clr_q  <= pend_clr_d;
      via_clr_q   <= via_clr_d;
      total_bcd_q <= total_bcd_d;
      high_bcd_q  <= high_bcd_d;
      busy_q      <= busy_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign total_bcd = total_bcd_q;
  assign high_bcd  = high_bcd_q;
  assign busy      = busy_q;
  assign bcd_valid = bcd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_score_board.sv
// ============================================================================
// tb_score_board : directed stimulus, score model with expectation queue
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_score_board;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  lvl;
  logic [23:0] score_in;
  logic        new_game;
  logic [23:0] total_bcd;
  logic [23:0] high_bcd;
  logic        busy;
  logic        bcd_valid;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int pulses    = 0;

  int m_total = 0;
  int m_high  = 0;
  logic [47:0] exp_q[$];

  score_board dut (
    .clk       (clk),
    .rst       (rst),
    .lvl       (lvl),
    .score_in  (score_in),
    .new_game  (new_game),
    .total_bcd (total_bcd),
    .high_bcd  (high_bcd),
    .busy      (busy),
    .bcd_valid (bcd_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic void model_add(input int s);
    m_total = m_total + s;
    if (m_total > 999999) m_total = 999999;
    if (m_total > m_high) m_high = m_total;
    exp_q.push_back({to_bcd(m_total), to_bcd(m_high)});
  endfunction

  function automatic void model_clr();
    if (m_total > m_high) m_high = m_total;
    m_total = 0;
    exp_q.push_back({to_bcd(m_total), to_bcd(m_high)});
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Every result pulse is compared with the model's next expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bcd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bcd_valid", 24'd1, 24'd0);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        check("model_total_bcd", total_bcd, e[47:24]);
        check("model_high_bcd", high_bcd, e[23:0]);
      end
      pulses++;
    end
  end

  task automatic drive_lvl(input logic [9:0] l, input logic [23:0] s);
    @(negedge clk);
    lvl      = l;
    score_in = s;
    model_add(int'(s));
  endtask

  task automatic wait_pulses(input int k);
    int target;
    target = pulses + k;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      #1;
      if (pulses >= target) break;
    end
    check("pulse_count", 24'(pulses), 24'(target));
  endtask

  // Event was driven just before; next posedge is the detection edge.
  task automatic measure_latency(input string name);
    int lat;
    logic busy_ok;
    lat = -1;
    busy_ok = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      @(negedge clk);
      new_game = 1'b0;
      if (n < 27 && busy !== 1'b1) busy_ok = 1'b0;
      if (bcd_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
    check({name, "_latency"}, 24'(lat), 24'd27);
    check({name, "_busy_held"}, {23'd0, busy_ok}, 24'd1);
    #1;
    check({name, "_busy_after"}, {23'd0, busy}, 24'd0);
  endtask

  initial begin
    logic quiet;
    int   p0;
    rst = 1'b1; lvl = 10'd3; score_in = 24'd0; new_game = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_total_bcd", total_bcd, 24'h0);
    check("rst_high_bcd", high_bcd, 24'h0);
    check("rst_busy", {23'd0, busy}, 24'd0);
    check("rst_bcd_valid", {23'd0, bcd_valid}, 24'd0);

    rst = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bcd_valid !== 1'b0 || busy !== 1'b0 || total_bcd !== 24'h0 || high_bcd !== 24'h0)
        quiet = 1'b0;
    end
    check("arming_quiet", {23'd0, quiet}, 24'd1);

    drive_lvl(10'd4, 24'd590);
    measure_latency("add590");
    check("lit_total_590", total_bcd, 24'h000590);
    check("lit_high_590", high_bcd, 24'h000590);

    drive_lvl(10'd5, 24'd300);
    wait_pulses(1);
    check("lit_total_890", total_bcd, 24'h000890);
    check("lit_high_890", high_bcd, 24'h000890);

    // Simultaneous new game and level change: clear first, bonus to the new game.
    @(negedge clk);
    lvl = 10'd6; score_in = 24'd120; new_game = 1'b1;
    model_clr();
    model_add(120);
    @(negedge clk);
    new_game = 1'b0;
    wait_pulses(1);
    check("ng_total_zero", total_bcd, 24'h000000);
    check("ng_high_kept", high_bcd, 24'h000890);
    wait_pulses(1);
    check("ng_total_120", total_bcd, 24'h000120);
    check("ng_high_still", high_bcd, 24'h000890);

    drive_lvl(10'd7, 24'd880);
    wait_pulses(1);
    check("lit_total_1000", total_bcd, 24'h001000);
    @(negedge clk);
    new_game = 1'b1;
    model_clr();
    measure_latency("newgame");
    check("ng2_high_1000", high_bcd, 24'h001000);
    check("ng2_total_zero", total_bcd, 24'h000000);

    drive_lvl(10'd8, 24'd999000);
    wait_pulses(1);
    drive_lvl(10'd9, 24'd5000);
    wait_pulses(1);
    check("sat_total", total_bcd, 24'h999999);
    drive_lvl(10'd10, 24'd10);
    wait_pulses(1);
    check("sat_total_again", total_bcd, 24'h999999);
    check("sat_high", high_bcd, 24'h999999);

    @(negedge clk);
    new_game = 1'b1;
    model_clr();
    @(negedge clk);
    new_game = 1'b0;
    wait_pulses(1);

    // Second level change lands while the first conversion is running.
    drive_lvl(10'd11, 24'd100);
    repeat (10) @(negedge clk);
    lvl = 10'd12; score_in = 24'd200;
    model_add(200);
    wait_pulses(2);
    check("conv_merge_total", total_bcd, 24'h000300);
    check("conv_merge_high", high_bcd, 24'h999999);

    drive_lvl(10'd13, 24'd50);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    m_total = 0;
    m_high  = 0;
    #1;
    check("midrst_total", total_bcd, 24'h0);
    check("midrst_high", high_bcd, 24'h0);
    check("midrst_busy", {23'd0, busy}, 24'd0);
    check("midrst_valid", {23'd0, bcd_valid}, 24'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p0 = pulses;
    repeat (60) @(negedge clk);
    #1;
    check("no_pulse_after_rst", 24'(pulses), 24'(p0));

    drive_lvl(10'd14, 24'd42);
    wait_pulses(1);
    check("post_rst_total", total_bcd, 24'h000042);
    check("post_rst_high", high_bcd, 24'h000042);

    repeat (5) @(negedge clk);
    check("queue_drained", 24'(exp_q.size()), 24'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

`default_nettype wire
